// File: rtl/rca_wb_stage.sv
// Writeback buffer stage behind the ripple-carry adder: small FIFO of results tagged with Z/N/V flags.
// Optional macro RCA_WB_SAT_EN saturates overflowing sums on push instead of storing the wrapped value.
module rca_wb_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SUM,
    input  logic             ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RESULT,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = WIDTH + 3;

    // Entry layout: {V, N, Z, data}
    logic [EW-1:0]    r_mem [DEPTH];
    logic [EW-1:0]    r_head;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_sticky;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_data;
    logic [EW-1:0]    w_entry;
    logic [PW-1:0]    w_rptr_nxt;
    logic [CW-1:0]    w_count_nxt;

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

`ifdef RCA_WB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    // A set MSB on an overflowing sum means a positive result wrapped negative.
    assign w_data = ovf ? (SUM[WIDTH-1] ? SAT_POS : SAT_NEG) : SUM;
`else
    assign w_data = SUM;
`endif

    assign w_entry = {ovf, w_data[WIDTH-1], (w_data == '0), w_data};

    always_comb begin
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        if (w_pop)
            w_rptr_nxt = r_rptr + PW'(1);
        if (w_push && !w_pop)
            w_count_nxt = r_count + CW'(1);
        else if (w_pop && !w_push)
            w_count_nxt = r_count - CW'(1);
    end

    // The head is registered so the outputs keep the last popped entry while empty;
    // the incoming entry becomes the head when it lands in the slot the read pointer moves to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= r_wptr + PW'(1);
            end
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            if (w_count_nxt != '0)
                r_head <= (w_push && (r_wptr == w_rptr_nxt)) ? w_entry : r_mem[w_rptr_nxt];
            if (w_push && ovf)
                r_sticky <= 1'b1;
            else if (clr_sticky)
                r_sticky <= 1'b0;
        end
    end

    assign RESULT     = r_head[WIDTH-1:0];
    assign flag_z     = r_head[WIDTH];
    assign flag_n     = r_head[WIDTH+1];
    assign flag_v     = r_head[WIDTH+2];
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_rca_wb_stage.sv
// Scoreboard bench for rca_wb_stage: operands are added as integers, and the expected entry is
// derived from the true sum; a negedge monitor checks handshake, head contents and sticky flag.
module tb_rca_wb_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [3:0] d;
        logic       z;
        logic       n;
        logic       v;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] SUM = '0;
    logic       ovf = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] RESULT;
    logic       flag_z, flag_n, flag_v;
    logic       ovf_sticky;
    logic       clr_sticky = 1'b0;

    rca_wb_stage #(.WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .SUM(SUM), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready),
        .RESULT(RESULT), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    ent_t exp_q[$];
    int   mcnt = 0;
    bit   exp_st = 1'b0;
    bit   started = 1'b0;
    ent_t last = '{d: 4'h0, z: 1'b0, n: 1'b0, v: 1'b0};
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: true signed sum of two 4-bit operands decides overflow and stored value.
    function automatic ent_t model(input int s);
        ent_t e;
        int   r;
        bit   o;
        o = (s > 7) || (s < -8);
        r = s;
`ifdef RCA_WB_SAT_EN
        if (s > 7) r = 7;
        else if (s < -8) r = -8;
`endif
        e.d = r[3:0];
        e.z = (e.d == 4'h0);
        e.n = e.d[3];
        e.v = o;
        return e;
    endfunction

    task automatic drive(input bit v, input int a, input int b, input bit ordy,
                         input bit clr, input bit r);
        int s;
        @(posedge clk);
        #1;
        s          = a + b;
        SUM        = s[3:0];
        ovf        = (s > 7) || (s < -8);
        in_valid   = v;
        out_ready  = ordy;
        clr_sticky = clr;
        rst        = r;
        if (v && !r && mcnt != DEPTH)
            exp_q.push_back(model(s));
    endtask

    always @(negedge clk) begin
        ent_t h;
        bit   acc, pop;
        if (started) begin
            chk("out_valid", {7'b0, out_valid}, {7'b0, (mcnt != 0)});
            chk("in_ready", {7'b0, in_ready}, {7'b0, (mcnt != DEPTH)});
            chk("ovf_sticky", {7'b0, ovf_sticky}, {7'b0, exp_st});
            if (mcnt != 0 && exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL scoreboard: got empty queue expected %0d entries at %0t", mcnt, $time);
                h = last;
            end else begin
                h = (mcnt != 0) ? exp_q[0] : last;
            end
            chk("RESULT", {4'b0, RESULT}, {4'b0, h.d});
            chk("flag_z", {7'b0, flag_z}, {7'b0, h.z});
            chk("flag_n", {7'b0, flag_n}, {7'b0, h.n});
            chk("flag_v", {7'b0, flag_v}, {7'b0, h.v});
        end
        if (rst) begin
            exp_q.delete();
            mcnt    = 0;
            exp_st  = 1'b0;
            last    = '{d: 4'h0, z: 1'b0, n: 1'b0, v: 1'b0};
            started = 1'b1;
        end else if (started) begin
            acc = in_valid && (mcnt != DEPTH);
            pop = (mcnt != 0) && out_ready;
            if (pop && exp_q.size() != 0)
                last = exp_q.pop_front();
            if (acc && ovf)
                exp_st = 1'b1;
            else if (clr_sticky)
                exp_st = 1'b0;
            mcnt = mcnt + int'(acc) - int'(pop);
        end
    end

    initial begin
        // reset, then single push and drain
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        drive(1, 3, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // zero and negative flags, in order
        drive(1, 0, 0, 1, 0, 0);
        drive(1, -6, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // fill with consumer stalled, third offer refused, head holds
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // one entry resident, simultaneous push and pop across pointer wrap
        drive(1, 4, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            drive(1, i - 3, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // overflow, sticky set beats clear, clear alone
        drive(1, 5, 3, 1, 0, 0);
        drive(1, 7, 7, 1, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(1, -8, -1, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // fill then reset with a valid offer
        drive(1, 2, 2, 0, 0, 0);
        drive(1, 5, 3, 0, 0, 0);
        drive(1, 6, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // random traffic
        for (int i = 0; i < 400; i++)
            drive($urandom_range(1, 0) == 1, int'($urandom_range(15, 0)) - 8,
                  int'($urandom_range(15, 0)) - 8, $urandom_range(3, 0) != 0,
                  $urandom_range(7, 0) == 0, $urandom_range(63, 0) == 0);
        for (int i = 0; i < 4; i++)
            drive(0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
